// File: rtl/fetch_sequencer.sv
// Program counter and fetch stage: drives the instruction ROM, resolves
// JMP/CALL/RET locally with a return stack and applies execute redirects.
module fetch_sequencer #(
    parameter int         ADDR_WIDTH  = 16,
    parameter int         INSTR_WIDTH = 28,
    parameter int         STACK_DEPTH = 4,
    parameter logic [3:0] OP_JMP      = 4'h5,
    parameter logic [3:0] OP_CALL     = 4'hA,
    parameter logic [3:0] OP_RET      = 4'hB
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [ADDR_WIDTH-1:0]  oRomAddress,
    input  logic [INSTR_WIDTH-1:0] iRomInstruction,
    input  logic                   iStall,
    input  logic                   iBranchTaken,
    input  logic [ADDR_WIDTH-1:0]  iBranchTarget,
    output logic [INSTR_WIDTH-1:0] oInstruction,
    output logic                   oValid,
    output logic [ADDR_WIDTH-1:0]  oPC,
    output logic                   oStackOverflow,
    output logic                   oStackUnderflow
);

    localparam int IDXW = $clog2(STACK_DEPTH);
    localparam int SPW  = IDXW + 1;

    typedef enum logic [1:0] {
        ST_START,
        ST_RUN,
        ST_HALT
    } state_t;

    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic [SPW-1:0]         sp_q;
    logic [INSTR_WIDTH-1:0] ir_q;
    logic                   valid_q;
    logic [ADDR_WIDTH-1:0]  opc_q;
    logic                   ovf_q;
    logic                   unf_q;
    logic [ADDR_WIDTH-1:0]  stack_q [STACK_DEPTH];

    logic [3:0]            opcode;
    logic [ADDR_WIDTH-1:0] target_d;
    logic [ADDR_WIDTH-1:0] pc_inc_d;
    logic                  full;
    logic                  empty;
    logic                  fetch_en;
    logic                  push_en;
    logic [IDXW-1:0]       push_idx;
    logic [IDXW-1:0]       pop_idx;

    always_comb begin
        opcode   = iRomInstruction[INSTR_WIDTH-1 -: 4];
        target_d = {{(ADDR_WIDTH-8){1'b0}},
                    iRomInstruction[INSTR_WIDTH-5 -: 8]};
        pc_inc_d = pc_q + ADDR_WIDTH'(1);
        full     = (sp_q == SPW'(STACK_DEPTH));
        empty    = (sp_q == '0);
        fetch_en = (state_q == ST_RUN) && !iBranchTaken && !iStall;
        push_en  = fetch_en && (opcode == OP_CALL) && !full;
        push_idx = sp_q[IDXW-1:0];
        pop_idx  = sp_q[IDXW-1:0] - IDXW'(1);
    end

    // Stack storage carries no reset; only the pointer is cleared.
    always_ff @(posedge Clock) begin
        if (push_en) begin
            stack_q[push_idx] <= pc_inc_d;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_START;
            pc_q    <= '0;
            sp_q    <= '0;
            ir_q    <= '0;
            valid_q <= 1'b0;
            opc_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    if (iBranchTaken) begin
                        pc_q    <= iBranchTarget;
                        valid_q <= 1'b0;
                    end else if (iStall) begin
                        state_q <= ST_RUN;
                    end else if (opcode == OP_CALL) begin
                        valid_q <= 1'b0;
                        if (full) begin
                            ovf_q   <= 1'b1;
                            state_q <= ST_HALT;
                        end else begin
                            sp_q <= sp_q + SPW'(1);
                            pc_q <= target_d;
                        end
                    end else if (opcode == OP_RET) begin
                        valid_q <= 1'b0;
                        if (empty) begin
                            unf_q   <= 1'b1;
                            state_q <= ST_HALT;
                        end else begin
                            sp_q <= sp_q - SPW'(1);
                            pc_q <= stack_q[pop_idx];
                        end
                    end else if (opcode == OP_JMP) begin
                        pc_q    <= target_d;
                        valid_q <= 1'b0;
                    end else begin
                        ir_q    <= iRomInstruction;
                        opc_q   <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                    end
                end
                ST_HALT: begin
                    valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_HALT;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign oRomAddress     = pc_q;
    assign oInstruction    = ir_q;
    assign oValid          = valid_q;
    assign oPC             = opc_q;
    assign oStackOverflow  = ovf_q;
    assign oStackUnderflow = unf_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a scoreboard of expected
// (pc, instruction) pairs consumed whenever a new valid word issues.
module tb_fetch_sequencer;

    localparam logic [3:0] OP_NORM = 4'h1;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_CALL = 4'hA;
    localparam logic [3:0] OP_RET  = 4'hB;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] oRomAddress;
    logic [27:0] iRomInstruction;
    logic        iStall = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic [15:0] iBranchTarget = '0;
    logic [27:0] oInstruction;
    logic        oValid;
    logic [15:0] oPC;
    logic        oStackOverflow;
    logic        oStackUnderflow;

    typedef struct packed {
        logic [15:0] pc;
        logic [27:0] ins;
    } exp_t;

    exp_t sbq[$];
    int   compared   = 0;
    int   mismatched = 0;
    logic stall_e;

    int ea[12] = '{0, 1, 2, 3, 4, 7, 8, 5, 6, 9, 10, 11};
    int ev[12] = '{0, 1, 1, 1, 1, 0, 1, 0, 1, 0, 1, 1};

    always #5 Clock = ~Clock;

    function automatic logic [27:0] rom_word(input logic [15:0] a);
        logic [7:0] nxt;
        nxt = a[7:0] + 8'h01;
        case (a)
            16'h0004: return {OP_CALL, 8'h07, 16'h0000};
            16'h0006: return {OP_JMP, 8'h09, 16'h0000};
            16'h0008: return {OP_RET, 24'h0};
            16'h0020, 16'h0021, 16'h0022, 16'h0023, 16'h0024:
                return {OP_CALL, nxt, 16'h0000};
            16'h0030: return {OP_RET, 24'h0};
            default:  return {OP_NORM, 8'h00, a};
        endcase
    endfunction

    assign iRomInstruction = rom_word(oRomAddress);

    fetch_sequencer #(
        .ADDR_WIDTH (16),
        .INSTR_WIDTH(28),
        .STACK_DEPTH(4),
        .OP_JMP     (OP_JMP),
        .OP_CALL    (OP_CALL),
        .OP_RET     (OP_RET)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .oRomAddress    (oRomAddress),
        .iRomInstruction(iRomInstruction),
        .iStall         (iStall),
        .iBranchTaken   (iBranchTaken),
        .iBranchTarget  (iBranchTarget),
        .oInstruction   (oInstruction),
        .oValid         (oValid),
        .oPC            (oPC),
        .oStackOverflow (oStackOverflow),
        .oStackUnderflow(oStackUnderflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] pc);
        exp_t e;
        e.pc  = pc;
        e.ins = rom_word(pc);
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    // A new word issues on an edge that left oValid high without a stall.
    always @(posedge Clock) begin
        exp_t e;
        stall_e = iStall;
        #1;
        if (!Reset && oValid && !stall_e) begin
            chk("sb_nonempty", {31'b0, sbq.size() != 0}, 32'd1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_pc", {16'h0, oPC}, {16'h0, e.pc});
                chk("sb_instr", {4'h0, oInstruction}, {4'h0, e.ins});
            end
        end
    end

    initial begin
        repeat (2) tick();
        chk("rst_addr", {16'h0, oRomAddress}, 32'h0);
        chk("rst_valid", {31'b0, oValid}, 32'h0);
        chk("rst_ovf", {31'b0, oStackOverflow}, 32'h0);
        chk("rst_unf", {31'b0, oStackUnderflow}, 32'h0);
        chk("rst_ir", {4'h0, oInstruction}, 32'h0);
        chk("rst_pc", {16'h0, oPC}, 32'h0);

        push(16'd0); push(16'd1); push(16'd2); push(16'd3);
        push(16'd7); push(16'd5); push(16'd9); push(16'd10);
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("seq_addr", {16'h0, oRomAddress}, 32'(ea[i]));
            chk("seq_valid", {31'b0, oValid}, 32'(ev[i]));
            if (i == 5)
                chk("call_ir_hold", {4'h0, oInstruction},
                    {4'h0, rom_word(16'd3)});
            if (i == 7)
                chk("ret_ir_hold", {4'h0, oInstruction},
                    {4'h0, rom_word(16'd7)});
        end

        iStall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", {16'h0, oRomAddress}, 32'd11);
            chk("stall_pc", {16'h0, oPC}, 32'd10);
            chk("stall_ir", {4'h0, oInstruction}, {4'h0, rom_word(16'd10)});
            chk("stall_valid", {31'b0, oValid}, 32'd1);
        end
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'h000A;
        tick();
        chk("stbr_addr", {16'h0, oRomAddress}, 32'h0A);
        chk("stbr_valid", {31'b0, oValid}, 32'h0);
        push(16'd10); push(16'd11);
        iBranchTaken = 1'b0;
        iStall       = 1'b0;
        repeat (2) tick();
        chk("resume_addr", {16'h0, oRomAddress}, 32'd12);

        iBranchTaken  = 1'b1;
        iBranchTarget = 16'hFFFF;
        tick();
        chk("wrap_pre", {16'h0, oRomAddress}, 32'hFFFF);
        push(16'hFFFF); push(16'h0000);
        iBranchTaken = 1'b0;
        tick();
        chk("wrap_addr", {16'h0, oRomAddress}, 32'h0);
        chk("wrap_pc", {16'h0, oPC}, 32'hFFFF);
        tick();

        iBranchTaken  = 1'b1;
        iBranchTarget = 16'h0020;
        tick();
        chk("nest_start", {16'h0, oRomAddress}, 32'h20);
        iBranchTaken = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("nest_addr", {16'h0, oRomAddress}, 32'(33 + k));
            chk("nest_ovf", {31'b0, oStackOverflow}, 32'h0);
        end
        tick();
        chk("ovf_flag", {31'b0, oStackOverflow}, 32'h1);
        chk("ovf_addr", {16'h0, oRomAddress}, 32'h24);
        chk("ovf_valid", {31'b0, oValid}, 32'h0);
        chk("ovf_unf", {31'b0, oStackUnderflow}, 32'h0);
        iBranchTaken  = 1'b1;
        iBranchTarget = 16'h0040;
        tick();
        chk("halt_br_ign", {16'h0, oRomAddress}, 32'h24);
        iBranchTaken = 1'b0;
        repeat (2) tick();
        chk("halt_addr", {16'h0, oRomAddress}, 32'h24);
        chk("halt_valid", {31'b0, oValid}, 32'h0);
        chk("halt_ovf", {31'b0, oStackOverflow}, 32'h1);

        #2 Reset = 1'b1;
        #1;
        chk("rr_addr", {16'h0, oRomAddress}, 32'h0);
        chk("rr_valid", {31'b0, oValid}, 32'h0);
        chk("rr_ovf", {31'b0, oStackOverflow}, 32'h0);
        chk("rr_unf", {31'b0, oStackUnderflow}, 32'h0);
        tick();
        push(16'd0);
        Reset = 1'b0;
        tick();
        chk("rel1_valid", {31'b0, oValid}, 32'h0);
        chk("rel1_addr", {16'h0, oRomAddress}, 32'h0);
        tick();
        chk("rel2_valid", {31'b0, oValid}, 32'h1);
        chk("rel2_pc", {16'h0, oPC}, 32'h0);

        iBranchTaken  = 1'b1;
        iBranchTarget = 16'h0004;
        tick();
        chk("brcall_addr", {16'h0, oRomAddress}, 32'h4);
        iBranchTarget = 16'h0030;
        tick();
        chk("brwin_addr", {16'h0, oRomAddress}, 32'h30);
        chk("brwin_valid", {31'b0, oValid}, 32'h0);
        iBranchTaken = 1'b0;
        tick();
        chk("unf_flag", {31'b0, oStackUnderflow}, 32'h1);
        chk("unf_ovf", {31'b0, oStackOverflow}, 32'h0);
        chk("unf_addr", {16'h0, oRomAddress}, 32'h30);
        chk("unf_valid", {31'b0, oValid}, 32'h0);
        tick();
        chk("unf_sticky", {31'b0, oStackUnderflow}, 32'h1);
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
